// File: rtl/systolic_seq_pkg.sv
// systolic_seq_pkg: shared types and helpers for the systolic tile sequencer.
//   seq_state_t : sequencer FSM state encoding (also exported for debug)
//   drain_len() : wavefront drain time in cycles for a DIM x DIM array
package systolic_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4,
    DONE  = 3'd5
  } seq_state_t;

  // Skew depth (dim-1) plus traversal of the array (dim).
  function automatic int drain_len(input int dim);
    return 2 * dim - 1;
  endfunction

endpackage

// File: rtl/systolic_tile_sequencer_if.sv
// systolic_tile_sequencer_if: all tile-level signals of the sequencer.
//   scheduler side : start, k_len (in); busy, done (out)
//   datapath side  : acc_clear, skew_clear, feed_en, feed_addr (out)
//   result stream  : out_valid, out_row, acc_shift (out); out_ready (in)
//   debug          : dbg_state (out), current FSM state
//   stall_cnt      : present only with SYSTOLIC_SEQ_PERF_CNT_EN
// Modport master is the sequencer; slave is the environment around it.
//
// Result handshake: a row beat transfers in every cycle where
// out_valid=1 and out_ready=1. While out_valid=1 and out_ready=0 the
// presented out_row is held unchanged; out_valid never drops before its
// beat transfers.
interface systolic_tile_sequencer_if
  import systolic_seq_pkg::*;
#(
  parameter int DIM = 4,
  parameter int K_W = 8
);
  logic                   start;
  logic [K_W-1:0]         k_len;
  logic                   busy;
  logic                   done;
  logic                   acc_clear;
  logic                   skew_clear;
  logic                   feed_en;
  logic [K_W-1:0]         feed_addr;
  logic                   out_valid;
  logic                   out_ready;
  logic [$clog2(DIM)-1:0] out_row;
  logic                   acc_shift;
  seq_state_t             dbg_state;
`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
  logic [31:0]            stall_cnt;
`endif

  modport master (
    input  start, k_len, out_ready,
    output busy, done, acc_clear, skew_clear, feed_en, feed_addr,
           out_valid, out_row, acc_shift, dbg_state
`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
    , output stall_cnt
`endif
  );

  modport slave (
    output start, k_len, out_ready,
    input  busy, done, acc_clear, skew_clear, feed_en, feed_addr,
           out_valid, out_row, acc_shift, dbg_state
`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
    , input stall_cnt
`endif
  );

endinterface

// File: rtl/seq_down_counter.sv
// seq_down_counter: loadable down counter with a zero flag.
//   clk, clear    : clock, synchronous active-low reset
//   load/load_val : load takes priority over decrement
//   dec           : decrement by one, sticks at zero
//   cnt, zero     : current count and cnt==0
module seq_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (!clear)                  cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (dec && cnt != '0)   cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/systolic_tile_sequencer.sv
// systolic_tile_sequencer: sequences one output tile through a DIM x DIM
// systolic array: clear -> feed k_len columns -> drain -> stream DIM rows.
//   clk   : single clock
//   clear : synchronous active-low reset, aborts any tile in flight
//   bus   : systolic_tile_sequencer_if.master (scheduler, datapath, result
//           stream and debug state)
// Optional feature macro SYSTOLIC_SEQ_PERF_CNT_EN adds bus.stall_cnt, the
// number of OUT cycles spent waiting on out_ready in the last tile.
module systolic_tile_sequencer
  import systolic_seq_pkg::*;
#(
  parameter int DIM = 4,
  parameter int K_W = 8
) (
  input  logic                         clk,
  input  logic                         clear,
  systolic_tile_sequencer_if.master    bus
);

  localparam int CW = $clog2(2 * DIM);
  localparam int RW = $clog2(DIM);

  seq_state_t     state, state_nx;
  logic [K_W-1:0] k_len_q;
  logic           accept;

  logic [K_W-1:0] feed_cnt;
  logic           feed_zero;
  logic [CW-1:0]  drain_cnt;
  logic           drain_zero;
  logic [CW-1:0]  beat_cnt;
  logic           beat_zero;
  logic [CW-1:0]  row_full;
  logic           drain_cnt_unused;

  assign accept = (state == IDLE) && bus.start;

  always_ff @(posedge clk) begin
    if (!clear) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = (bus.k_len != '0) ? CLR : DONE;
      CLR:     state_nx = FEED;
      FEED:    if (feed_zero) state_nx = DRAIN;
      DRAIN:   if (drain_zero) state_nx = OUT;
      OUT:     if (bus.acc_shift && beat_zero) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear)      k_len_q <= '0;
    else if (accept) k_len_q <= bus.k_len;
  end

  // Each counter is loaded in the cycle before its state is entered, so it
  // holds (length-1) on the first cycle and reaches zero on the last one.
  seq_down_counter #(.W(K_W)) u_feed_cnt (
    .clk      (clk),
    .clear    (clear),
    .load     (state == CLR),
    .load_val (k_len_q - K_W'(1)),
    .dec      (state == FEED),
    .cnt      (feed_cnt),
    .zero     (feed_zero)
  );

  seq_down_counter #(.W(CW)) u_drain_cnt (
    .clk      (clk),
    .clear    (clear),
    .load     ((state == FEED) && feed_zero),
    .load_val (CW'(drain_len(DIM) - 1)),
    .dec      (state == DRAIN),
    .cnt      (drain_cnt),
    .zero     (drain_zero)
  );

  seq_down_counter #(.W(CW)) u_beat_cnt (
    .clk      (clk),
    .clear    (clear),
    .load     ((state == DRAIN) && drain_zero),
    .load_val (CW'(DIM - 1)),
    .dec      (bus.acc_shift),
    .cnt      (beat_cnt),
    .zero     (beat_zero)
  );

  assign drain_cnt_unused = ^drain_cnt;

  // Address and row index count up; derive them from the down counters.
  assign row_full = CW'(DIM - 1) - beat_cnt;

  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.acc_clear  = (state == CLR);
  assign bus.skew_clear = (state == CLR);
  assign bus.feed_en    = (state == FEED);
  assign bus.feed_addr  = (state == FEED) ? (k_len_q - K_W'(1) - feed_cnt) : '0;
  assign bus.out_valid  = (state == OUT);
  assign bus.out_row    = (state == OUT) ? row_full[RW-1:0] : '0;
  assign bus.acc_shift  = bus.out_valid & bus.out_ready;
  assign bus.dbg_state  = state;

`ifdef SYSTOLIC_SEQ_PERF_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (!clear)      stall_q <= '0;
    else if (accept) stall_q <= '0;
    else if (bus.out_valid && !bus.out_ready && stall_q != 32'hFFFF_FFFF)
      stall_q <= stall_q + 32'd1;
  end

  assign bus.stall_cnt = stall_q;
`endif

endmodule
